// File: rtl/opb_master_arbiter.sv
// ----------------------------------------------------------------------------
// opb_master_arbiter
//   Two-requester, single-beat OPB master. Requester 0 (host bridge) and
//   requester 1 (internal sequencer) share one decoder port under
//   round-robin arbitration. Each transaction is sequenced as
//   IDLE -> ISSUE -> [WAIT x READ_LAT] -> DONE -> [GAP x TURNAROUND] -> IDLE.
//
// Parameters
//   READ_LAT    cycles from the DEC_RE cycle to valid DEC_DO (1..4)
//   TURNAROUND  strobe-free cycles forced after every ACK (0..7)
//
// Ports
//   OPB_CLK, OPB_RST_N             clock, asynchronous active-low reset
//   Mx_REQ/RNW/ADDR/WDATA          requester x transaction (held until ACK)
//   Mx_ACK                         one-cycle completion pulse
//   Mx_RDATA                       read data, held until next read by x
//   DEC_RE/DEC_WE                  one-cycle decoder strobes
//   DEC_ADDR/DEC_DI                address / write data, held between txns
//   DEC_DO                         registered read data from the decoder
//   GRANT                          one-hot owner from ISSUE through DONE
//   BUSY                           high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module opb_master_arbiter #(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST_N,

    input  logic        M0_REQ,
    input  logic        M0_RNW,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic [31:0] M0_RDATA,

    input  logic        M1_REQ,
    input  logic        M1_RNW,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic [31:0] M1_RDATA,

    output logic        DEC_RE,
    output logic        DEC_WE,
    output logic [31:0] DEC_ADDR,
    output logic [31:0] DEC_DI,
    input  logic [31:0] DEC_DO,

    output logic [1:0]  GRANT,
    output logic        BUSY
);

    // Wide enough for both READ_LAT (max 4) and TURNAROUND (max 7).
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              state_q;
    logic                owner_q;       // 0 = M0, 1 = M1
    logic                rnw_q;
    logic                last_grant_q;  // owner of the most recent grant
    logic [CNT_W-1:0]    cnt_q;         // WAIT latency / GAP length counter
    logic                dec_re_q;
    logic                dec_we_q;
    logic [DATA_W-1:0]   dec_addr_q;
    logic [DATA_W-1:0]   dec_di_q;
    logic                m0_ack_q;
    logic                m1_ack_q;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic [DATA_W-1:0]   m1_rdata_q;
    logic [1:0]          grant_q;
    logic                busy_q;

    // Arbitration decision, only consumed in IDLE.
    logic                grant_vld_c;
    logic                pick_c;
    logic                sel_rnw_c;
    logic [DATA_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

    // Round robin: on contention the requester that did not win last time wins.
    always_comb begin
        grant_vld_c = 1'b0;
        pick_c      = 1'b0;
        if (M0_REQ && M1_REQ) begin
            grant_vld_c = 1'b1;
            pick_c      = ~last_grant_q;
        end else if (M0_REQ) begin
            grant_vld_c = 1'b1;
            pick_c      = 1'b0;
        end else if (M1_REQ) begin
            grant_vld_c = 1'b1;
            pick_c      = 1'b1;
        end
    end

    // Payload mux for the chosen requester.
    always_comb begin
        sel_rnw_c   = M0_RNW;
        sel_addr_c  = M0_ADDR;
        sel_wdata_c = M0_WDATA;
        if (pick_c) begin
            sel_rnw_c   = M1_RNW;
            sel_addr_c  = M1_ADDR;
            sel_wdata_c = M1_WDATA;
        end
    end

    // Transaction sequencer; every output is a flop so strobes never
    // see a combinational path from requester inputs.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            rnw_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            dec_re_q     <= 1'b0;
            dec_we_q     <= 1'b0;
            dec_addr_q   <= '0;
            dec_di_q     <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            // Strobes and ACKs are single-cycle pulses unless re-armed below.
            dec_re_q <= 1'b0;
            dec_we_q <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (grant_vld_c) begin
                        owner_q      <= pick_c;
                        rnw_q        <= sel_rnw_c;
                        last_grant_q <= pick_c;
                        dec_addr_q   <= sel_addr_c;
                        dec_di_q     <= sel_wdata_c;
                        dec_re_q     <= sel_rnw_c;
                        dec_we_q     <= ~sel_rnw_c;
                        grant_q      <= pick_c ? 2'b10 : 2'b01;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (rnw_q) begin
                        cnt_q   <= CNT_W'(READ_LAT);
                        state_q <= S_WAIT;
                    end else begin
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= S_DONE;
                    end
                end

                // Decoder output is valid in the last WAIT cycle (cnt == 1).
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (owner_q) begin
                            m1_rdata_q <= DEC_DO;
                        end else begin
                            m0_rdata_q <= DEC_DO;
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= S_DONE;
                    end
                end

                S_DONE: begin
                    grant_q <= 2'b00;
                    if (TURNAROUND > 0) begin
                        cnt_q   <= CNT_W'(TURNAROUND);
                        state_q <= S_GAP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_GAP: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DEC_RE   = dec_re_q;
    assign DEC_WE   = dec_we_q;
    assign DEC_ADDR = dec_addr_q;
    assign DEC_DI   = dec_di_q;
    assign M0_ACK   = m0_ack_q;
    assign M1_ACK   = m1_ack_q;
    assign M0_RDATA = m0_rdata_q;
    assign M1_RDATA = m1_rdata_q;
    assign GRANT    = grant_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_opb_master_arbiter
//   Two arbiter instances: A (READ_LAT=1, TURNAROUND=1) and
//   B (READ_LAT=3, TURNAROUND=0). Each has a decoder model whose DEC_DO is
//   valid only exactly READ_LAT cycles after DEC_RE. Requester index
//   k = dut*2 + requester. Expected transactions are queued when a request
//   is driven and retired by the negedge monitor at strobe and at ACK.
// ----------------------------------------------------------------------------
module tb_opb_master_arbiter;

    localparam int unsigned LAT_A = 1;
    localparam int unsigned TA_A  = 1;
    localparam int unsigned LAT_B = 3;
    localparam int unsigned TA_B  = 0;
    localparam logic [31:0] JUNK  = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst_n    [2];
    logic        req      [4];
    logic        rnw      [4];
    logic [31:0] addr     [4];
    logic [31:0] wdata    [4];
    logic        ack      [4];
    logic [31:0] rdata    [4];
    logic        dec_re   [2];
    logic        dec_we   [2];
    logic [31:0] dec_addr [2];
    logic [31:0] dec_di   [2];
    logic [31:0] dec_do   [2];
    logic [1:0]  grant    [2];
    logic        busy     [2];
    logic [32:0] pipe     [2][4];

    int          vectors;
    int          miscompares;
    int          cyc;
    txn_t        strobe_q   [4][$];
    txn_t        ack_q      [4][$];
    logic [31:0] exp_rd     [4];
    int          strobe_cyc [2];
    int          last_ack   [2];
    int          owner_log  [2][$];
    int          gap_log    [2][$];
    int          ackcyc_log [4][$];

    function automatic int lat_of(input int d);
        return (d == 0) ? int'(LAT_A) : int'(LAT_B);
    endfunction

    function automatic int ta_of(input int d);
        return (d == 0) ? int'(TA_A) : int'(TA_B);
    endfunction

    function automatic logic [31:0] rd_value(input logic [31:0] a);
        return 32'hA5A5_0000 | (a >> 6);
    endfunction

    opb_master_arbiter #(.READ_LAT(LAT_A), .TURNAROUND(TA_A)) u_dut_a (
        .OPB_CLK(clk), .OPB_RST_N(rst_n[0]),
        .M0_REQ(req[0]), .M0_RNW(rnw[0]), .M0_ADDR(addr[0]), .M0_WDATA(wdata[0]),
        .M0_ACK(ack[0]), .M0_RDATA(rdata[0]),
        .M1_REQ(req[1]), .M1_RNW(rnw[1]), .M1_ADDR(addr[1]), .M1_WDATA(wdata[1]),
        .M1_ACK(ack[1]), .M1_RDATA(rdata[1]),
        .DEC_RE(dec_re[0]), .DEC_WE(dec_we[0]), .DEC_ADDR(dec_addr[0]),
        .DEC_DI(dec_di[0]), .DEC_DO(dec_do[0]),
        .GRANT(grant[0]), .BUSY(busy[0])
    );

    opb_master_arbiter #(.READ_LAT(LAT_B), .TURNAROUND(TA_B)) u_dut_b (
        .OPB_CLK(clk), .OPB_RST_N(rst_n[1]),
        .M0_REQ(req[2]), .M0_RNW(rnw[2]), .M0_ADDR(addr[2]), .M0_WDATA(wdata[2]),
        .M0_ACK(ack[2]), .M0_RDATA(rdata[2]),
        .M1_REQ(req[3]), .M1_RNW(rnw[3]), .M1_ADDR(addr[3]), .M1_WDATA(wdata[3]),
        .M1_ACK(ack[3]), .M1_RDATA(rdata[3]),
        .DEC_RE(dec_re[1]), .DEC_WE(dec_we[1]), .DEC_ADDR(dec_addr[1]),
        .DEC_DI(dec_di[1]), .DEC_DO(dec_do[1]),
        .GRANT(grant[1]), .BUSY(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered decoder model: data valid only READ_LAT cycles after DEC_RE.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= {dec_re[d], rd_value(dec_addr[d])};
            for (int i = 1; i < 4; i++) pipe[d][i] <= pipe[d][i-1];
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            dec_do[d] = pipe[d][lat_of(d)-1][32] ? pipe[d][lat_of(d)-1][31:0] : JUNK;
        end
    end

    // Negedge monitor: retires scoreboard entries at strobe and ACK.
    initial begin : monitor
        txn_t t;
        int   k0, k, r, gap, lat, exp_lat;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                k0 = d * 2;
                if (!rst_n[d]) begin
                    vectors++;
                    if ({ack[k0], ack[k0+1], rdata[k0], rdata[k0+1], dec_re[d], dec_we[d],
                         dec_addr[d], dec_di[d], grant[d], busy[d]} !== '0) begin
                        miscompares++;
                        $display("FAIL reset_outputs dut%0d: re=%0b we=%0b ack=%0b%0b grant=%b busy=%0b addr=%h di=%h rd0=%h rd1=%h, all required 0",
                                 d, dec_re[d], dec_we[d], ack[k0], ack[k0+1], grant[d], busy[d],
                                 dec_addr[d], dec_di[d], rdata[k0], rdata[k0+1]);
                    end
                    for (int j = 0; j < 2; j++) begin
                        strobe_q[k0+j].delete();
                        ack_q[k0+j].delete();
                        exp_rd[k0+j] = 32'h0;
                    end
                    last_ack[d] = -1000;
                end else begin
                    if (dec_re[d] || dec_we[d]) begin
                        vectors++;
                        if ((dec_re[d] && dec_we[d]) || busy[d] !== 1'b1 ||
                            (grant[d] !== 2'b01 && grant[d] !== 2'b10)) begin
                            miscompares++;
                            $display("FAIL strobe_state dut%0d: re=%0b we=%0b grant=%b busy=%0b, required one strobe, one-hot grant, busy=1",
                                     d, dec_re[d], dec_we[d], grant[d], busy[d]);
                        end else begin
                            r = (grant[d] == 2'b10) ? 1 : 0;
                            k = k0 + r;
                            if (strobe_q[k].size() == 0) begin
                                miscompares++;
                                $display("FAIL unexpected_strobe dut%0d req%0d: re=%0b addr=%h, required no strobe",
                                         d, r, dec_re[d], dec_addr[d]);
                            end else begin
                                t   = strobe_q[k].pop_front();
                                gap = cyc - last_ack[d];
                                if (dec_re[d] !== t.rnw || dec_addr[d] !== t.addr ||
                                    (!t.rnw && dec_di[d] !== t.wdata) || gap < ta_of(d) + 2) begin
                                    miscompares++;
                                    $display("FAIL strobe_payload dut%0d req%0d: got re=%0b addr=%h di=%h gap=%0d, required re=%0b addr=%h di=%h gap>=%0d",
                                             d, r, dec_re[d], dec_addr[d], dec_di[d], gap,
                                             t.rnw, t.addr, t.wdata, ta_of(d) + 2);
                                end
                                owner_log[d].push_back(r);
                                gap_log[d].push_back(gap);
                                strobe_cyc[d] = cyc;
                            end
                        end
                    end
                    for (int j = 0; j < 2; j++) begin
                        k = k0 + j;
                        if (ack[k]) begin
                            vectors++;
                            if (ack_q[k].size() == 0) begin
                                miscompares++;
                                $display("FAIL unexpected_ack dut%0d req%0d: ack=1, required 0", d, j);
                            end else begin
                                t       = ack_q[k].pop_front();
                                lat     = cyc - strobe_cyc[d];
                                exp_lat = t.rnw ? 1 + lat_of(d) : 1;
                                if (lat != exp_lat || grant[d] !== (j == 1 ? 2'b10 : 2'b01)) begin
                                    miscompares++;
                                    $display("FAIL ack_timing dut%0d req%0d: strobe->ack=%0d grant=%b, required %0d grant=%b",
                                             d, j, lat, grant[d], exp_lat, (j == 1 ? 2'b10 : 2'b01));
                                end
                                if (t.rnw) exp_rd[k] = rd_value(t.addr);
                                last_ack[d] = cyc;
                                ackcyc_log[k].push_back(cyc);
                            end
                        end
                    end
                    vectors++;
                    if (!busy[d] && grant[d] !== 2'b00) begin
                        miscompares++;
                        $display("FAIL idle_grant dut%0d: grant=%b while idle, required 00", d, grant[d]);
                    end
                    for (int j = 0; j < 2; j++) begin
                        vectors++;
                        if (rdata[k0+j] !== exp_rd[k0+j]) begin
                            miscompares++;
                            $display("FAIL rdata dut%0d req%0d: got %h, required %h",
                                     d, j, rdata[k0+j], exp_rd[k0+j]);
                        end
                    end
                end
            end
        end
    end

    // Issue n transactions from one requester, holding REQ between them.
    // mode: 0 write, 1 read, 2 alternate starting read, 3 alternate starting write.
    task automatic drive_seq(input int d, input int r, input int n,
                             input logic [31:0] abase, input logic [31:0] wbase, input int mode);
        int   k;
        int   w;
        txn_t t;
        k = d * 2 + r;
        for (int i = 0; i < n; i++) begin
            t.rnw   = (mode == 1) || (mode == 2 && (i % 2) == 0) || (mode == 3 && (i % 2) == 1);
            t.addr  = abase + 32'(i * 16);
            t.wdata = wbase + 32'(i);
            rnw[k]   = t.rnw;
            addr[k]  = t.addr;
            wdata[k] = t.wdata;
            req[k]   = 1'b1;
            strobe_q[k].push_back(t);
            ack_q[k].push_back(t);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!ack[k] && w < 100);
            if (!ack[k]) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_timeout dut%0d req%0d: no ack within %0d cycles", d, r, w);
                break;
            end
        end
        req[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[k]   = 1'b1;
            rnw[k]   = 1'b1;
            addr[k]  = 32'h0000_0010;
            wdata[k] = 32'h1234_5678;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (dec_re[0] || dec_we[0] || dec_re[1] || dec_we[1] || busy[0] || busy[1]) begin
            miscompares++;
            $display("FAIL reset_hold: re=%0b%0b we=%0b%0b busy=%0b%0b, required all 0",
                     dec_re[0], dec_re[1], dec_we[0], dec_we[1], busy[0], busy[1]);
        end
        #2;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        fork
            drive_seq(0, 0, 1, 32'h0000_0200, 32'h0, 1);
            drive_seq(0, 1, 1, 32'h0000_0300, 32'h1111_0000, 0);
            drive_seq(1, 0, 1, 32'h0000_0400, 32'h0, 1);
            drive_seq(1, 1, 1, 32'h0000_0500, 32'h2222_0000, 0);
            begin
                // Grant taken at the first edge after release; M0 wins.
                @(negedge clk);
                vectors++;
                if (grant[0] !== 2'b01 || dec_re[0] !== 1'b1 || grant[1] !== 2'b01 || dec_re[1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_grant: grant=%b/%b re=%0b/%0b, required 01/01 re=1/1",
                             grant[0], grant[1], dec_re[0], dec_re[1]);
                end
            end
        join
    endtask

    task automatic test_m0_read();
        drive_seq(0, 0, 1, 32'h0000_0040, 32'h0, 1);
        vectors++;
        if (rdata[0] !== 32'hA5A5_0001 || rdata[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL m0_read: m0_rdata=%h m1_rdata=%h, required a5a50001 00000000", rdata[0], rdata[1]);
        end
    endtask

    task automatic test_m1_write();
        drive_seq(0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (dec_addr[0] !== 32'h0000_0100 || dec_di[0] !== 32'hDEAD_BEEF || rdata[0] !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL m1_write_hold: addr=%h di=%h m0_rdata=%h, required 00000100 deadbeef a5a50001",
                     dec_addr[0], dec_di[0], rdata[0]);
        end
    endtask

    // Previous grant on each instance went to M1, so M0 leads.
    task automatic test_round_robin(input int d);
        owner_log[d].delete();
        gap_log[d].delete();
        fork
            drive_seq(d, 0, 4, 32'h0000_1000, 32'hC0DE_0000, 2);
            drive_seq(d, 1, 4, 32'h0000_2000, 32'hF00D_0000, 3);
        join
        vectors++;
        if (owner_log[d].size() != 8) begin
            miscompares++;
            $display("FAIL rr_count dut%0d: %0d grants, required 8", d, owner_log[d].size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (owner_log[d][i] != (i % 2)) begin
                    miscompares++;
                    $display("FAIL rr_order dut%0d grant %0d: owner %0d, required %0d", d, i, owner_log[d][i], i % 2);
                end
                if (i > 0) begin
                    vectors++;
                    if (gap_log[d][i] != ta_of(d) + 2) begin
                        miscompares++;
                        $display("FAIL rr_gap dut%0d grant %0d: ack->strobe %0d, required %0d",
                                 d, i, gap_log[d][i], ta_of(d) + 2);
                    end
                end
            end
        end
    endtask

    // ACK period with REQ held: IDLE + ISSUE + READ_LAT*WAIT + DONE + TURNAROUND*GAP.
    task automatic test_back_to_back();
        int exp_per;
        exp_per = lat_of(1) + 3 + ta_of(1);
        ackcyc_log[2].delete();
        drive_seq(1, 0, 4, 32'h0000_3000, 32'h0, 1);
        vectors++;
        if (ackcyc_log[2].size() != 4) begin
            miscompares++;
            $display("FAIL b2b_count: %0d acks, required 4", ackcyc_log[2].size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (ackcyc_log[2][i] - ackcyc_log[2][i-1] != exp_per) begin
                    miscompares++;
                    $display("FAIL b2b_period ack %0d: %0d cycles, required %0d",
                             i, ackcyc_log[2][i] - ackcyc_log[2][i-1], exp_per);
                end
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy[1] !== 1'b0 || grant[1] !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_idle: busy=%0b grant=%b, required 0 00", busy[1], grant[1]);
        end
    endtask

    task automatic test_reset_mid();
        txn_t t;
        int   w;
        t.rnw = 1'b1; t.addr = 32'h0000_0080; t.wdata = 32'h0;
        rnw[0] = 1'b1; addr[0] = t.addr; wdata[0] = t.wdata; req[0] = 1'b1;
        strobe_q[0].push_back(t);
        ack_q[0].push_back(t);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!dec_re[0] && w < 50);
        vectors++;
        if (!dec_re[0]) begin
            miscompares++;
            $display("FAIL mid_issue_timeout: no DEC_RE within %0d cycles", w);
        end
        @(negedge clk);
        vectors++;
        if (busy[0] !== 1'b1 || grant[0] !== 2'b01 || ack[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_wait: busy=%0b grant=%b ack=%0b, required 1 01 0", busy[0], grant[0], ack[0]);
        end
        #2;
        rst_n[0] = 1'b0;
        req[0]   = 1'b0;
        #1;
        vectors++;
        if ({dec_re[0], dec_we[0], ack[0], ack[1], rdata[0], rdata[1], grant[0], busy[0]} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: re=%0b we=%0b ack=%0b%0b rd0=%h rd1=%h grant=%b busy=%0b, required all 0",
                     dec_re[0], dec_we[0], ack[0], ack[1], rdata[0], rdata[1], grant[0], busy[0]);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_quiet cycle %0d: ack=%0b busy=%0b, required 0 0", i, ack[0], busy[0]);
            end
        end
        drive_seq(0, 0, 1, 32'h0000_00C0, 32'h0, 1);
        vectors++;
        if (rdata[0] !== 32'hA5A5_0003) begin
            miscompares++;
            $display("FAIL post_reset_read: m0_rdata=%h, required a5a50003", rdata[0]);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 4; k++) begin
            req[k] = 1'b0; rnw[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
            exp_rd[k] = 32'h0;
        end
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        last_ack[0] = -1000;
        last_ack[1] = -1000;
        strobe_cyc[0] = 0;
        strobe_cyc[1] = 0;

        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin(0);
        test_round_robin(1);
        test_back_to_back();
        test_reset_mid();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
